// File: rtl/mem_line_dma.sv
// mem_line_dma: splits whole cache-line read/write requests into memory beats
// and reassembles read beats into a single line response.
module mem_line_dma #(
    parameter int block_size_p     = 8,
    parameter int dma_data_width_p = 2,
    parameter int addr_width_p     = 32
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic                            req_we_i,
    input  logic [addr_width_p-1:0]         req_addr_i,
    input  logic [block_size_p*32-1:0]      req_wdata_i,
    output logic                            resp_valid_o,
    input  logic                            resp_ready_i,
    output logic                            resp_we_o,
    output logic [block_size_p*32-1:0]      resp_data_o,
    output logic                            mem_valid_o,
    input  logic                            mem_ready_i,
    output logic                            mem_we_o,
    output logic [addr_width_p-1:0]         mem_addr_o,
    output logic [dma_data_width_p*32-1:0]  mem_wdata_o,
    input  logic                            mem_valid_i,
    input  logic [dma_data_width_p*32-1:0]  mem_data_i
);
    localparam int beats_lp = block_size_p / dma_data_width_p;
    localparam int bw_lp    = dma_data_width_p * 32;
    localparam int cw_lp    = $clog2(beats_lp + 1);
    localparam int off_lp   = $clog2(block_size_p * 4);
    localparam logic [cw_lp-1:0]        last_lp    = cw_lp'(beats_lp - 1);
    localparam logic [cw_lp-1:0]        full_lp    = cw_lp'(beats_lp);
    localparam logic [addr_width_p-1:0] lo_mask_lp = addr_width_p'((1 << off_lp) - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t                     r_state, w_next;
    logic [addr_width_p-1:0]    r_addr;
    logic                       r_we;
    logic [block_size_p*32-1:0] r_wdata, r_rdata;
    logic [cw_lp-1:0]           r_issue_cnt, r_rcv_cnt;
    logic                       w_accept, w_issue, w_rcv;

    assign w_accept    = req_valid_i & req_ready_o;
    assign w_issue     = mem_valid_o & mem_ready_i;
    // Returned data only counts while a read is collecting; anything else is stray.
    assign w_rcv       = (r_state == READ) & mem_valid_i & (r_rcv_cnt != full_lp);
    assign mem_addr_o  = r_addr + addr_width_p'(r_issue_cnt) * addr_width_p'(dma_data_width_p * 4);
    assign resp_we_o   = r_we;
    assign resp_data_o = r_rdata;

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) r_state <= IDLE;
        else         r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid_i) w_next = req_we_i ? WRITE : READ;
            WRITE:   if (w_issue && r_issue_cnt == last_lp) w_next = RESP;
            READ:    if (w_rcv && r_rcv_cnt == last_lp) w_next = RESP;
            RESP:    if (resp_ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = r_state == IDLE;
        resp_valid_o = r_state == RESP;
        mem_we_o     = r_state == WRITE;
        mem_valid_o  = (r_state == WRITE) | ((r_state == READ) & (r_issue_cnt != full_lp));
        mem_wdata_o  = '0;
        for (int k = 0; k < beats_lp; k++)
            if (r_issue_cnt == cw_lp'(k)) mem_wdata_o = r_wdata[k*bw_lp +: bw_lp];
    end

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_issue_cnt <= '0;
            r_rcv_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_addr      <= req_addr_i & ~lo_mask_lp;
                r_we        <= req_we_i;
                r_wdata     <= req_wdata_i;
                r_issue_cnt <= '0;
                r_rcv_cnt   <= '0;
            end else begin
                if (w_issue) r_issue_cnt <= r_issue_cnt + cw_lp'(1);
                if (w_rcv)   r_rcv_cnt   <= r_rcv_cnt + cw_lp'(1);
            end
            for (int k = 0; k < beats_lp; k++)
                if (w_rcv && r_rcv_cnt == cw_lp'(k)) r_rdata[k*bw_lp +: bw_lp] <= mem_data_i;
        end
endmodule
